muldiv_sequencer: RTL and testbench

- Sequences the shared multi-cycle multiply and divide units and commits their results into the HI and LO registers.
- Sits between the main control FSM and the mult/div datapath.
- The main FSM issues a one-cycle start, then stalls on `busy` until `done`.
- The block drives `initMult`/`initDiv`, the `OPhi`/`OPLow` result-mux selects and `HIWrite`/`LOWrite`, and flags divide-by-zero for the exception path.

---
 rtl/muldiv_sequencer.sv | 166 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Sequencer for the shared multi-cycle multiply/divide units: issues init pulses,
// waits out the unit latency, commits HI/LO and reports completion or divide-by-zero.
module muldiv_sequencer #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] divisor,
    input  logic        abort,
    output logic        initMult,
    output logic        initDiv,
    output logic        OPhi,
    output logic        OPLow,
    output logic        HIWrite,
    output logic        LOWrite,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_DZERO = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_q, op_d;

    logic init_mult_q, init_mult_d;
    logic init_div_q, init_div_d;
    logic op_sel_q, op_sel_d;
    logic hilo_write_q, hilo_write_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic div_zero_q, div_zero_d;

    // Next-state, counter and op-latch logic; abort from any active state wins over everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (abort) begin
                        state_d = ST_IDLE;
                    end else if (start_mult) begin
                        op_d    = 1'b1;
                        cnt_d   = MULT_LOAD;
                        state_d = ST_RUN;
                    end else if (start_div) begin
                        if (divisor != 32'd0) begin
                            op_d    = 1'b0;
                            cnt_d   = DIV_LOAD;
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_DZERO;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        state_d = ST_WRITE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_WRITE: state_d = ST_DONE;
                ST_DONE:  state_d = ST_IDLE;
                ST_DZERO: state_d = ST_IDLE;
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Output decode from next-state values so every output leaves a flop one cycle later.
    always_comb begin
        init_mult_d  = 1'b0;
        init_div_d   = 1'b0;
        hilo_write_d = 1'b0;
        done_d       = 1'b0;
        div_zero_d   = 1'b0;
        busy_d       = (state_d != ST_IDLE);
        op_sel_d     = op_d;
        case (state_d)
            ST_RUN: begin
                // The counter only decreases in RUN, so the load value marks the first cycle.
                init_mult_d = op_d && (cnt_d == MULT_LOAD);
                init_div_d  = !op_d && (cnt_d == DIV_LOAD);
            end
            ST_WRITE: hilo_write_d = 1'b1;
            ST_DONE:  done_d = 1'b1;
            ST_DZERO: begin
                done_d     = 1'b1;
                div_zero_d = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // State, counter and op latch registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            op_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_mult_q  <= 1'b0;
            init_div_q   <= 1'b0;
            op_sel_q     <= 1'b0;
            hilo_write_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            div_zero_q   <= 1'b0;
        end else begin
            init_mult_q  <= init_mult_d;
            init_div_q   <= init_div_d;
            op_sel_q     <= op_sel_d;
            hilo_write_q <= hilo_write_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            div_zero_q   <= div_zero_d;
        end
    end

    assign initMult = init_mult_q;
    assign initDiv  = init_div_q;
    assign OPhi     = op_sel_q;
    assign OPLow    = op_sel_q;
    assign HIWrite  = hilo_write_q;
    assign LOWrite  = hilo_write_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed scenarios plus random traffic,
// compared every cycle against a schedule model (cycle offsets from the accepting edge).
module tb_muldiv_sequencer;

    localparam int MULT_N = 32;
    localparam int DIV_N  = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_mult = 1'b0;
    logic        start_div = 1'b0;
    logic [31:0] divisor = 32'd0;
    logic        abort = 1'b0;
    logic        initMult, initDiv, OPhi, OPLow, HIWrite, LOWrite, busy, done, div_zero;
    logic [8:0]  outs_s;

    int n_pass  = 0;
    int n_total = 0;

    // model: active op, kind (0 mult, 1 div, 2 div-by-zero), age in cycles since accept
    bit m_active = 1'b0;
    int m_kind   = 0;
    int m_k      = 0;
    bit m_op     = 1'b0;

    muldiv_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
        .divisor(divisor), .abort(abort), .initMult(initMult), .initDiv(initDiv),
        .OPhi(OPhi), .OPLow(OPLow), .HIWrite(HIWrite), .LOWrite(LOWrite),
        .busy(busy), .done(done), .div_zero(div_zero)
    );

    assign outs_s = {initMult, initDiv, OPhi, OPLow, HIWrite, LOWrite, busy, done, div_zero};

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s t=%0t got=%b expected=%b", tag, $time, obs[8:0], exp[8:0]);
        end
    endtask

    function automatic int op_len(input int kind);
        return (kind == 0) ? MULT_N : DIV_N;
    endfunction

    function automatic logic [31:0] model_outs();
        int  n;
        bit  im, idv, wr, dn, dz;
        n  = op_len(m_kind);
        im = m_active && (m_kind == 0) && (m_k == 1);
        idv = m_active && (m_kind == 1) && (m_k == 1);
        wr = m_active && (m_kind != 2) && (m_k == n + 1);
        dz = m_active && (m_kind == 2) && (m_k == 1);
        dn = dz || (m_active && (m_kind != 2) && (m_k == n + 2));
        return {23'd0, im, idv, m_op, m_op, wr, wr, m_active, dn, dz};
    endfunction

    task automatic model_edge();
        int last;
        last = (m_kind == 2) ? 1 : op_len(m_kind) + 2;
        if (m_active) begin
            if (abort || (m_k == last)) m_active = 1'b0;
            else m_k++;
        end else if (!abort) begin
            if (start_mult) begin
                m_active = 1'b1; m_kind = 0; m_k = 1; m_op = 1'b1;
            end else if (start_div) begin
                m_active = 1'b1; m_k = 1;
                if (divisor != 32'd0) begin
                    m_kind = 1; m_op = 1'b0;
                end else begin
                    m_kind = 2;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_val("outs", {23'd0, outs_s}, model_outs());
    endtask

    task automatic cyc(input logic sm, input logic sd, input logic [31:0] dv, input logic ab);
        start_mult = sm;
        start_div  = sd;
        divisor    = dv;
        abort      = ab;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        #1;
        check_val("reset_outs", {23'd0, outs_s}, 32'd0);
        #11;
        reset = 1'b1;

        // mult sequence
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        idle(36);
        // div with nonzero divisor
        cyc(1'b0, 1'b1, 32'd7, 1'b0);
        idle(36);
        // divide by zero
        cyc(1'b0, 1'b1, 32'd0, 1'b0);
        idle(3);
        // both starts together, then a stray start_div mid-run
        cyc(1'b1, 1'b1, 32'd5, 1'b0);
        idle(8);
        cyc(1'b0, 1'b1, 32'd3, 1'b0);
        idle(30);
        // abort during cycle 20 of a div run
        cyc(1'b0, 1'b1, 32'd9, 1'b0);
        idle(19);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        idle(15);
        // abort on the edge that would enter WRITE
        cyc(1'b0, 1'b1, 32'd9, 1'b0);
        idle(31);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        idle(5);
        // back-to-back: start on the edge leaving DONE is dropped, next one accepted
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        idle(33);
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, 32'd4, 1'b0);
        idle(36);
        // asynchronous reset mid-run
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        idle(10);
        #3;
        reset = 1'b0;
        #1;
        check_val("async_rst", {23'd0, outs_s}, 32'd0);
        m_active = 1'b0;
        m_op     = 1'b0;
        @(posedge clk);
        #2;
        check_val("rst_held", {23'd0, outs_s}, 32'd0);
        reset = 1'b1;
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        idle(36);

        // random traffic; abort only while an op is in flight
        for (int i = 0; i < 3000; i++) begin
            logic        sm, sd, ab;
            logic [31:0] dv;
            sm = ($urandom_range(0, 11) == 0);
            sd = ($urandom_range(0, 9) == 0);
            dv = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            ab = m_active && ($urandom_range(0, 39) == 0);
            cyc(sm, sd, dv, ab);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
